dmem_responder: RTL and testbench

Responder (memory side) for the core's data port. It serves loads and stores from a word-organised RAM and carries a small MMIO window. The window holds a test-completion register, a 64-bit cycle counter and sticky error capture. The block instantiates next to the core in simulation and FPGA tops, and gives benches a self-checking end-of-test signal.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/dmem_regs.sv | 90 +++++++++
 rtl/dmem_responder.sv | 90 +++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the core's data port and the dmem responder.
// Includes the access-size encoding, the MMIO register offsets and the lane helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [2:0] acc_size_t;

  localparam acc_size_t ACC_BYTE = 3'b001;
  localparam acc_size_t ACC_HALF = 3'b010;
  localparam acc_size_t ACC_WORD = 3'b100;

  localparam logic [3:0] TOHOST_OFS   = 4'h0;
  localparam logic [3:0] CYCLE_LO_OFS = 4'h4;
  localparam logic [3:0] CYCLE_HI_OFS = 4'h8;
  localparam logic [3:0] ERR_ADR_OFS  = 4'hC;

  // Right-justified data mask for a legal access size.
  function automatic logic [XLEN-1:0] size_mask(input acc_size_t size);
    case (size)
      ACC_BYTE: return 32'h0000_00FF;
      ACC_HALF: return 32'h0000_FFFF;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Byte enables for a lane-0 access; the caller shifts them by adr[1:0].
  function automatic logic [3:0] size_be(input acc_size_t size);
    case (size)
      ACC_BYTE: return 4'b0001;
      ACC_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_regs.sv
// MMIO register file of the dmem responder: free-running 64-bit cycle counter,
// CYCLE_HI shadow, first-write-wins TOHOST flags and sticky error capture.
module dmem_regs
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            acc_v_i,
  input  logic            is_store_i,
  input  logic [3:0]      ofs_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            err_v_i,
  input  logic [XLEN-1:0] err_adr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            test_done_o,
  output logic            test_pass_o,
  output logic            err_o,
  output logic [XLEN-1:0] err_adr_o
);

  logic [63:0]     cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] err_adr_q, err_adr_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if tree can leave a latch behind.
  always_comb begin
    cnt_d     = cnt_q + 64'd1;
    hi_d      = hi_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    rdata_o   = '0;

    if (acc_v_i) begin
      case (ofs_i)
        TOHOST_OFS: begin
          rdata_o = {30'b0, pass_q, done_q};
          if (is_store_i && !done_q) begin
            done_d = 1'b1;
            pass_d = (wdata_i == 32'd1);
          end
        end
        CYCLE_LO_OFS: begin
          rdata_o = cnt_q[31:0];
          // Snapshot the upper half so a following HI read pairs with this LO.
          if (!is_store_i) hi_d = cnt_q[63:32];
        end
        CYCLE_HI_OFS: rdata_o = hi_q;
        ERR_ADR_OFS:  rdata_o = err_adr_q;
        default:      rdata_o = '0;
      endcase
    end

    if (err_v_i) begin
      err_d = 1'b1;
      if (!err_q) err_adr_d = err_adr_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign test_done_o = done_q;
  assign test_pass_o = pass_q;
  assign err_o       = err_q;
  assign err_adr_o   = err_adr_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: word RAM with byte lanes,
// zero-latency loads, address decode and the MMIO window in dmem_regs.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'h1000_0000,
  parameter string           INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  acc_size_t       access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            test_done_o,
  output logic            test_pass_o,
  output logic            err_o,
  output logic [XLEN-1:0] err_adr_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN:0] RAM_END = {1'b0, RAM_BASE} + (XLEN+1)'(4 * DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic             size_ok, misaligned, ram_hit, mmio_hit, acc_err;
  logic             ram_v, mmio_v, ram_we;
  logic [IDX_W-1:0] ram_idx;
  logic [4:0]       lane_sh;
  logic [3:0]       wr_be;
  logic [XLEN-1:0]  wr_data, rd_word, mmio_rdata;

  always_comb begin
    size_ok    = (access_size_i == ACC_BYTE) || (access_size_i == ACC_HALF) ||
                 (access_size_i == ACC_WORD);
    misaligned = ((access_size_i == ACC_HALF) && adr_i[0]) ||
                 ((access_size_i == ACC_WORD) && (adr_i[1:0] != 2'b00));
    ram_hit    = ({1'b0, adr_i} >= {1'b0, RAM_BASE}) && ({1'b0, adr_i} < RAM_END);
    mmio_hit   = (adr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
    acc_err    = adr_v_i && (!size_ok || misaligned || (!ram_hit && !mmio_hit) ||
                             (mmio_hit && (access_size_i != ACC_WORD)));

    // The MMIO window wins should it ever overlap the RAM range.
    mmio_v  = adr_v_i && !acc_err && mmio_hit;
    ram_v   = adr_v_i && !acc_err && ram_hit && !mmio_hit;
    ram_we  = ram_v && is_store_i;
    ram_idx = IDX_W'((adr_i - RAM_BASE) >> 2);
    lane_sh = {adr_i[1:0], 3'b000};
    wr_be   = size_be(access_size_i) << adr_i[1:0];
    wr_data = store_data_i << lane_sh;
    rd_word = mem[ram_idx];

    load_data_o = '0;
    if (!is_store_i) begin
      if (ram_v)       load_data_o = (rd_word >> lane_sh) & size_mask(access_size_i);
      else if (mmio_v) load_data_o = mmio_rdata;
    end
  end

  // NOTE: the RAM array has no reset; clearing it would need a per-word
  // reset path and its content must survive a mid-test reset anyway.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[ram_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  dmem_regs u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .acc_v_i     (mmio_v),
    .is_store_i  (is_store_i),
    .ofs_i       (adr_i[3:0]),
    .wdata_i     (store_data_i),
    .err_v_i     (acc_err),
    .err_adr_i   (adr_i),
    .rdata_o     (mmio_rdata),
    .test_done_o (test_done_o),
    .test_pass_o (test_pass_o),
    .err_o       (err_o),
    .err_adr_o   (err_adr_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM lanes, TOHOST,
// error capture, counter carry consistency and asynchronous reset.
module tb_dmem_responder;
  import riscv_pkg::*;

  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adr_v;
  logic [31:0] adr;
  logic        is_store;
  logic [31:0] store_data;
  logic [2:0]  acc_size;
  logic [31:0] load_data;
  logic        test_done, test_pass, err;
  logic [31:0] err_adr;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v),
    .adr_i         (adr),
    .is_store_i    (is_store),
    .store_data_i  (store_data),
    .access_size_i (acc_size),
    .load_data_o   (load_data),
    .test_done_o   (test_done),
    .test_pass_o   (test_pass),
    .err_o         (err),
    .err_adr_o     (err_adr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic st,
                       input logic [31:0] d, input logic [2:0] sz);
    adr_v = v; adr = a; is_store = st; store_data = d; acc_size = sz;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    @(negedge clk);
    drive(1'b1, a, 1'b1, d, sz);
    @(posedge clk); #1;
    adr_v = 1'b0;
  endtask

  task automatic load_get(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] val);
    @(negedge clk);
    drive(1'b1, a, 1'b0, 32'h0, sz);
    #1 val = load_data;
    @(posedge clk); #1;
    adr_v = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] exp);
    logic [31:0] v;
    load_get(a, sz, v);
    check(tag, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, ACC_WORD);
    #12;
    check("rst_done", {31'b0, test_done}, 32'd0);
    check("rst_pass", {31'b0, test_pass}, 32'd0);
    check("rst_err",  {31'b0, err}, 32'd0);
    check("rst_err_adr", err_adr, 32'd0);
    drive(1'b1, MMIO + 32'h4, 1'b0, 32'h0, ACC_WORD);
    #1 check("rst_cycle_lo", load_data, 32'd0);
    drive(1'b1, MMIO + 32'h8, 1'b0, 32'h0, ACC_WORD);
    #1 check("rst_cycle_hi", load_data, 32'd0);
    adr_v = 1'b0;
    @(negedge clk) reset_n = 1'b1;

    // Counter advances once per clock.
    load_get(MMIO + 32'h4, ACC_WORD, a);
    repeat (4) @(posedge clk);
    load_get(MMIO + 32'h4, ACC_WORD, b);
    check("cnt_delta", b - a, 32'd5);

    // Lane steering on loads and stores.
    store(32'h0, 32'hA5A5_A5A5, ACC_WORD);
    store(32'h100, 32'hDEAD_BEEF, ACC_WORD);
    load_chk("ld_word_100", 32'h100, ACC_WORD, 32'hDEAD_BEEF);
    load_chk("ld_byte_103", 32'h103, ACC_BYTE, 32'h0000_00DE);
    load_chk("ld_half_102", 32'h102, ACC_HALF, 32'h0000_DEAD);
    load_chk("ld_byte_100", 32'h100, ACC_BYTE, 32'h0000_00EF);
    load_chk("ld_half_100", 32'h100, ACC_HALF, 32'h0000_BEEF);
    store(32'h101, 32'h0000_0055, ACC_BYTE);
    load_chk("st_byte_101", 32'h100, ACC_WORD, 32'hDEAD_55EF);
    store(32'h102, 32'h0000_1234, ACC_HALF);
    load_chk("st_half_102", 32'h100, ACC_WORD, 32'h1234_55EF);
    store(32'h100, 32'hFFFF_FF77, ACC_BYTE);
    load_chk("st_byte_junk", 32'h100, ACC_WORD, 32'h1234_5577);

    // Load data is zero when idle or during a store.
    @(negedge clk);
    drive(1'b0, 32'h100, 1'b0, 32'h0, ACC_WORD);
    #1 check("ld_idle_zero", load_data, 32'h0);
    drive(1'b1, 32'h200, 1'b1, 32'h1122_3344, ACC_WORD);
    #1 check("ld_store_zero", load_data, 32'h0);
    @(posedge clk); #1 adr_v = 1'b0;
    load_chk("ld_word_200", 32'h200, ACC_WORD, 32'h1122_3344);

    // Last RAM word is legal.
    store(32'h3FFC, 32'hCAFE_F00D, ACC_WORD);
    load_chk("ld_last_word", 32'h3FFC, ACC_WORD, 32'hCAFE_F00D);

    // TOHOST: first write wins.
    check("done_before", {31'b0, test_done}, 32'd0);
    store(MMIO, 32'h1, ACC_WORD);
    check("done_after", {31'b0, test_done}, 32'd1);
    check("pass_after", {31'b0, test_pass}, 32'd1);
    store(MMIO, 32'h3, ACC_WORD);
    check("pass_sticky", {31'b0, test_pass}, 32'd1);
    load_chk("ld_tohost", MMIO, ACC_WORD, 32'h3);

    // Error capture.
    check("err_before", {31'b0, err}, 32'd0);
    load_chk("ld_half_201", 32'h201, ACC_HALF, 32'h0);
    check("err_set", {31'b0, err}, 32'd1);
    check("err_adr_201", err_adr, 32'h201);
    store(32'h201, 32'h0000_FFFF, ACC_HALF);
    load_chk("ram_kept_200", 32'h200, ACC_WORD, 32'h1122_3344);
    load_chk("ld_word_7", 32'h7, ACC_WORD, 32'h0);
    check("err_adr_first", err_adr, 32'h201);
    store(32'h4000, 32'h0000_0BAD, ACC_WORD);
    load_chk("ram_kept_0", 32'h0, ACC_WORD, 32'hA5A5_A5A5);
    load_chk("ld_past_end", 32'h4000, ACC_WORD, 32'h0);
    load_chk("ld_size_011", 32'h200, 3'b011, 32'h0);
    load_chk("ld_mmio_byte", MMIO + 32'h4, ACC_BYTE, 32'h0);
    load_chk("ld_unmapped", 32'h2000_0000, ACC_WORD, 32'h0);
    load_chk("ld_err_adr_reg", MMIO + 32'hC, ACC_WORD, 32'h201);

    // CYCLE_LO/HI pair across a low-word carry.
    @(negedge clk);
    force dut.u_regs.cnt_q = 64'h0000_0000_FFFF_FFFF;
    drive(1'b1, MMIO + 32'h4, 1'b0, 32'h0, ACC_WORD);
    #1 check("carry_lo", load_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    force dut.u_regs.cnt_q = 64'h0000_0001_0000_0000;
    adr_v = 1'b0;
    load_chk("carry_hi", MMIO + 32'h8, ACC_WORD, 32'h0);
    @(negedge clk);
    release dut.u_regs.cnt_q;
    load_get(MMIO + 32'h4, ACC_WORD, a);
    load_chk("hi_after_lo", MMIO + 32'h8, ACC_WORD, 32'h1);

    // Asynchronous reset mid-test; RAM content survives.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_done", {31'b0, test_done}, 32'd0);
    check("arst_pass", {31'b0, test_pass}, 32'd0);
    check("arst_err",  {31'b0, err}, 32'd0);
    check("arst_err_adr", err_adr, 32'h0);
    drive(1'b1, MMIO + 32'h4, 1'b0, 32'h0, ACC_WORD);
    #1 check("arst_cycle_lo", load_data, 32'h0);
    drive(1'b1, 32'h100, 1'b0, 32'h0, ACC_WORD);
    #1 check("arst_ram_kept", load_data, 32'h1234_5577);
    adr_v = 1'b0;
    @(negedge clk) reset_n = 1'b1;

    // A first TOHOST write other than 1 reports failure.
    store(MMIO, 32'h2, ACC_WORD);
    check("done_fail_run", {31'b0, test_done}, 32'd1);
    check("pass_fail_run", {31'b0, test_pass}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
